// File: rtl/lcd_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sequencer_if
//   Groups the PIO-side command/status words and the HD44780 LCD pins that
//   the sequencer drives.
//
//   Signals:
//     cmd_word  [15:0] : PIO out_port word. [15] request toggle, [8] RS,
//                        [7:0] data/command byte, [14:9] ignored.
//     status    [15:0] : {14'b0, busy, ack} for the PIO in_port.
//     lcd_data  [7:0]  : LCD DB7..DB0.
//     lcd_rs           : LCD register select.
//     lcd_rw           : LCD R/W, always 0 (write-only).
//     lcd_en           : LCD enable strobe.
//     state_dbg [2:0]  : current sequencer state, for observation only.
//
//   Modports:
//     slave  : the sequencer (consumes cmd_word, drives everything else).
//     master : the PIO / bench side.
// ---------------------------------------------------------------------------
interface lcd_cmd_sequencer_if;
  logic [15:0] cmd_word;
  logic [15:0] status;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic [2:0]  state_dbg;

  modport slave (
    input  cmd_word,
    output status,
    output lcd_data,
    output lcd_rs,
    output lcd_rw,
    output lcd_en,
    output state_dbg
  );

  modport master (
    output cmd_word,
    input  status,
    input  lcd_data,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_en,
    input  state_dbg
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sequencer
//   Takes one command word at a time from a Nios II PIO and plays it onto an
//   HD44780-compatible LCD bus with setup, enable-pulse, hold and execution
//   timing, then toggles ack so software can issue the next command.
//
//   Handshake (toggle based): a request is pending while cmd_word[15] != ack.
//   Software writes new RS/data together with a flipped [15] in one write,
//   then polls status until ack == cmd_word[15]. cmd_word is only sampled in
//   IDLE; anything written while busy is ignored until the FSM is back in
//   IDLE, so two flips during one busy period cancel out and are lost.
//
//   Ports:
//     clk      : system clock (50 MHz).
//     reset_n  : asynchronous, active-low reset.
//     bus      : lcd_cmd_sequencer_if.slave (cmd_word in; status, LCD pins,
//                state_dbg out).
//
//   All outputs are registered; there is no combinational path from
//   cmd_word to the LCD pins.
// ---------------------------------------------------------------------------
module lcd_cmd_sequencer #(
  parameter int SETUP_CYC     = 4,
  parameter int EN_CYC        = 25,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2500,
  parameter int EXEC_LONG_CYC = 82000,
  parameter int CNT_W         = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lcd_cmd_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // Counter reload values: the counter holds N-1 on entry to a state and the
  // state advances on the cycle it is found at zero, giving N cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(EXEC_LONG_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ack;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             long_q;
  logic             en_q;
  logic             accept;
  logic             ack_flip;
  logic             long_d;
  logic             busy;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign long_d = ~bus.cmd_word[8] &&
                  (bus.cmd_word[7:2] == 6'd0) &&
                  (bus.cmd_word[7:0] != 8'd0);

  // Bits [14:9] of the PIO word carry nothing for this block.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^bus.cmd_word[14:9];

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept   = 1'b0;
    ack_flip = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_word[15] != ack) begin
          state_n = S_SETUP;
          cnt_n   = SETUP_LD;
          accept  = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_n = S_PULSE;
          cnt_n   = EN_LD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          state_n = S_HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_n = S_WAIT;
          cnt_n   = long_q ? LONG_LD : EXEC_LD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n  = S_IDLE;
          ack_flip = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ack    <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // RS/data are latched once per command and left in place afterwards.
      if (accept) begin
        rs_q   <= bus.cmd_word[8];
        data_q <= bus.cmd_word[7:0];
        long_q <= long_d;
      end
      if (ack_flip) begin
        ack <= ~ack;
      end
      // Registered strobe, high exactly while the FSM sits in PULSE.
      en_q <= (state_n == S_PULSE);
    end
  end

  assign busy          = (state != S_IDLE);
  assign bus.status    = {14'b0, busy, ack};
  assign bus.lcd_data  = data_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_en    = en_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_sequencer
//   Directed bench for lcd_cmd_sequencer with short timing parameters
//   (SETUP=2, EN=3, HOLD=1, EXEC=4, EXEC_LONG=8). Inputs are driven and
//   outputs sampled on the falling clock edge; the DUT acts on rising edges.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_sequencer;

  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 1;
  localparam int X  = 4;
  localparam int XL = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_cmd_sequencer_if bus ();

  lcd_cmd_sequencer #(
    .SETUP_CYC    (S),
    .EN_CYC       (E),
    .HOLD_CYC     (H),
    .EXEC_CYC     (X),
    .EXEC_LONG_CYC(XL),
    .CNT_W        (18)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Runs one command window. Sample 0 is taken after the edge that accepts
  // the request; sample T = S+E+H+exp_wait is the first one back in IDLE.
  // Optional mid-flight writes to cmd_word are applied after samples m1_at /
  // m2_at (use -1 to skip).
  task automatic run_cmd(input string tag, input bit drive, input logic [15:0] word,
                         input int m1_at, input logic [15:0] m1_word,
                         input int m2_at, input logic [15:0] m2_word,
                         input int exp_wait, input logic exp_rs,
                         input logic [7:0] exp_data, input logic exp_ack);
    int t;
    int en_first;
    int en_cnt;
    int busy_len;
    int bad;
    logic [15:0] st0;
    t        = S + E + H + exp_wait;
    en_first = -1;
    en_cnt   = 0;
    busy_len = -1;
    bad      = 0;
    st0      = 16'hxxxx;
    if (drive) bus.cmd_word = word;
    for (int i = 0; i <= t; i++) begin
      @(negedge clk);
      if (i == 0) st0 = bus.status;
      if (bus.lcd_en === 1'b1) begin
        en_cnt++;
        if (en_first < 0) en_first = i;
      end
      if (bus.status[1] !== 1'b1 && busy_len < 0) busy_len = i;
      if (i < S + E + H &&
          (bus.lcd_data !== exp_data || bus.lcd_rs !== exp_rs || bus.lcd_rw !== 1'b0))
        bad++;
      if (i == m1_at) bus.cmd_word = m1_word;
      if (i == m2_at) bus.cmd_word = m2_word;
    end
    check({tag, "/status_start"}, 32'(st0), {16'd0, 14'b0, 1'b1, ~exp_ack});
    check({tag, "/en_rise_at"},   en_first, S);
    check({tag, "/en_width"},     en_cnt, E);
    check({tag, "/busy_cycles"},  busy_len, t);
    check({tag, "/bus_stable"},   bad, 0);
    check({tag, "/status_end"},   32'(bus.status), {16'd0, 14'b0, 1'b0, exp_ack});
    check({tag, "/state_end"},    32'(bus.state_dbg), 32'd0);
  endtask

  // Watches n idle cycles: status must stay put, no strobe, bus unchanged.
  task automatic idle_watch(input string tag, input int n, input logic [15:0] exp_status,
                            input logic [7:0] exp_data);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.status !== exp_status || bus.lcd_en !== 1'b0 || bus.lcd_data !== exp_data)
        bad++;
    end
    check({tag, "/idle_bad"}, bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n      = 1'b0;
    bus.cmd_word = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst/status",   32'(bus.status), 32'h0000);
    check("rst/lcd_data", 32'(bus.lcd_data), 32'h00);
    check("rst/lcd_rs",   32'(bus.lcd_rs), 32'h0);
    check("rst/lcd_rw",   32'(bus.lcd_rw), 32'h0);
    check("rst/lcd_en",   32'(bus.lcd_en), 32'h0);
    check("rst/state",    32'(bus.state_dbg), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted mid-PULSE clears outputs immediately.
    bus.cmd_word = 16'h8077;
    repeat (4) @(negedge clk);
    check("rst_mid/en_before", 32'(bus.lcd_en), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_mid/en_after",     32'(bus.lcd_en), 32'h0);
    check("rst_mid/status_after", 32'(bus.status), 32'h0000);
    check("rst_mid/data_after",   32'(bus.lcd_data), 32'h00);
    bus.cmd_word = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    idle_watch("rst_release", 5, 16'h0000, 8'h00);

    // Data write: RS=1, 0x41, normal wait, ack 0 -> 1.
    run_cmd("data", 1'b1, 16'h8141, -1, 16'h0, -1, 16'h0, X, 1'b1, 8'h41, 1'b1);

    // Clear display: long wait, ack 1 -> 0.
    run_cmd("long", 1'b1, 16'h0001, -1, 16'h0, -1, 16'h0, XL, 1'b0, 8'h01, 1'b0);

    // 0x04 is an ordinary command (normal wait).
    run_cmd("notlong", 1'b1, 16'h8004, -1, 16'h0, -1, 16'h0, X, 1'b0, 8'h04, 1'b1);

    // Payload rewritten mid-PULSE without a toggle: no effect, no extra command.
    run_cmd("nochange", 1'b1, 16'h0123, 3, 16'h01FF, -1, 16'h0, X, 1'b1, 8'h23, 1'b0);
    idle_watch("nochange", 6, 16'h0000, 8'h23);

    // Request queued during WAIT starts one cycle after the first ack.
    run_cmd("queue1", 1'b1, 16'h8130, 7, 16'h0055, -1, 16'h0, X, 1'b1, 8'h30, 1'b1);
    run_cmd("queue2", 1'b0, 16'h0000, -1, 16'h0, -1, 16'h0, X, 1'b0, 8'h55, 1'b0);

    // Two toggles while busy: only the first command runs.
    run_cmd("dbl", 1'b1, 16'h8166, 2, 16'h0199, 5, 16'h81AA, X, 1'b1, 8'h66, 1'b1);
    idle_watch("dbl", 6, 16'h0001, 8'h66);
    check("dbl/ack_eq_toggle", 32'(bus.status[0]), 32'(bus.cmd_word[15]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Consumer side of the 16-bit LCD output PIO: takes the command word that the Nios II writes through the PIO and drives an HD44780-compatible character LCD bus with correct setup, enable-pulse, hold and execution timing. It returns a status word for a companion PIO input port, so software can handshake one command at a time instead of bit-banging the enable line. It sits in the Qsys top level between the PIO `out_port` and the board LCD pins.

## Interface
Parameters:
- SETUP_CYC, 4: cycles RS/DATA are stable before `lcd_en` rises (≥1).
- EN_CYC, 25: `lcd_en` high width in cycles (≥1).
- HOLD_CYC, 2: cycles RS/DATA remain stable after `lcd_en` falls (≥1).
- EXEC_CYC, 2500: post-command wait for normal commands and data writes (≥1).
- EXEC_LONG_CYC, 82000: post-command wait for clear/home commands (≥1).
- CNT_W, 18: internal counter width; must hold max(all *_CYC).

Ports:
- clk, in, 1: system clock, 50 MHz.
- reset_n, in, 1: asynchronous, active-low reset.
- cmd_word, in, 16: from the PIO. [15] = request toggle, [8] = RS, [7:0] = data/command byte, [14:9] ignored.
- lcd_data, out, 8: LCD DB7..DB0.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD R/W, constant 0 (write-only).
- lcd_en, out, 1: LCD enable strobe.
- status, out, 16: {14'b0, busy, ack} for the PIO input port.

## Operation
- Handshake is toggle-based:
  - A request is pending when `cmd_word[15] != ack`.
  - Software changes [8:0] and flips [15] in one write, then polls until `ack == cmd_word[15]`.
- The FSM has states IDLE, SETUP, PULSE, HOLD, WAIT.
- **IDLE:** if a request is pending:
  - latch `cmd_word[8:0]` into RS/DATA registers;
  - latch long = (RS==0 && data[7:2]==0 && data!=0), i.e. commands 0x01, 0x02, 0x03;
  - go to SETUP and load the counter.
- **SETUP:** `lcd_rs` and `lcd_data` are driven from the latches; `lcd_en` is 0. Lasts SETUP_CYC cycles, then goes to PULSE.
- **PULSE:** `lcd_en` is 1. Lasts EN_CYC cycles, then goes to HOLD.
- **HOLD:** `lcd_en` is 0 and RS/DATA are unchanged. Lasts HOLD_CYC cycles, then goes to WAIT.
- **WAIT:** lasts EXEC_LONG_CYC cycles if long, else EXEC_CYC. On exit, ack toggles and the FSM returns to IDLE.
- `busy` = (state != IDLE).
- `cmd_word` is sampled only in IDLE. Changes to it while busy do not affect the command in flight.
- If [15] is flipped twice while busy, no request is pending at IDLE and the second command is lost. This is a software contract violation, and no error is flagged.
- `lcd_data`/`lcd_rs` keep their last driven values in IDLE and are not cleared.
- The counter is a CNT_W-bit down-counter loaded with N-1 on state entry; the state advances when it reaches 0.

## Timing
- Reset values: `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0, `status`=0x0000, state=IDLE, ack=0, counter=0.
- A request visible at clock edge k (state IDLE) gives:
  - SETUP from edge k;
  - `lcd_en` high from edge k+SETUP_CYC to edge k+SETUP_CYC+EN_CYC;
  - ack toggle and busy fall at edge k+S+E+H+X, where X is the EXEC value selected.
- `busy` rises at edge k: one cycle after the write that created the request, if that write landed at edge k-1.
- Back-to-back commands: a pending request at the same edge that returns the FSM to IDLE is accepted one edge later. There is at least 1 IDLE cycle between commands.
- All outputs are registered; there are no combinational paths from `cmd_word` to the LCD pins.
- Reset mid-operation (any state): all outputs go to their reset values asynchronously, including `lcd_en`. After release, a request is pending if `cmd_word[15]`==1.

## Test plan
All scenarios use SETUP=2, EN=3, HOLD=1, EXEC=4, EXEC_LONG=8.
- **Reset:** assert `reset_n`=0 mid-PULSE → `lcd_en`=0 and `status`=0x0000 immediately. After release with `cmd_word`=0x0000, the FSM stays IDLE and `lcd_en` stays 0.
- **Data write:** `cmd_word`=0x8141 → `lcd_rs`=1 and `lcd_data`=0x41 for 2 cycles before `lcd_en` rises; `lcd_en` is high for exactly 3 cycles; data is held 1 cycle after; `status` goes 0x0002 → 0x0001 at 10 cycles after acceptance.
- **Long command:** from ack=1, `cmd_word`=0x0001 → `lcd_rs`=0, `lcd_data`=0x01, WAIT lasts 8 cycles, total busy 14 cycles, `status` ends 0x0000. Repeat with 0x0004 → WAIT lasts 4 cycles (not long).
- **No change while busy:** change `cmd_word[8:0]` mid-PULSE to 0x1FF without flipping [15] → bus keeps the original values and no second command is issued.
- **Queued request:** flip [15] with a new byte 0x55 during WAIT → second command starts 1 cycle after the first ack, with `lcd_data`=0x55.
- **Double toggle while busy:** flip [15] twice while busy → exactly one command executes and ack ends equal to `cmd_word[15]`.
